hex_loader: RTL
===============

Name: hex_loader

Overview:
- Parametrised successor to the HEXBIN converter: a streaming Intel HEX record parser that emits byte-wide memory writes.
- Consumes one ASCII character per EN strobe and decodes record types 00/01/02/04.
- Builds a full AW-bit address from extended segment/linear bases, verifies per-record checksums, and reports DONE on EOF.
- Sits between a UART/ROM character source and a boot-RAM write port.

Parameters:
- AW, 32, address bus width (legal 16..32); addresses are truncated to AW bits.
- ALLOW_LC, 1, 1 = accept lowercase a-f as hex digits; 0 = lowercase is a bad character.

Ports:
- CLK  input  1  system clock, rising edge.
- CLR  input  1  asynchronous active-low reset (clears when 0).
- EN  input  1  character strobe; DI is sampled on a CLK edge only when EN=1.
- DI  input  8  ASCII character.
- AB  output  AW  write address, valid while WE=1.
- DB  output  8  write data, valid while WE=1.
- WE  output  1  one-cycle write pulse per data byte.
- REC_OK  output  1  one-cycle pulse when a record's checksum verifies.
- DONE  output  1  sticky; set by a valid EOF record.
- ERR  output  1  sticky error flag.
- ERR_CODE  output  2  0 none, 1 bad character, 2 checksum mismatch, 3 illegal length for type.

Behaviour:
- Reset (CLR=0): AB=0, DB=0, WE=0, REC_OK=0, DONE=0, ERR=0, ERR_CODE=0, base=0, state=IDLE.
- Reset takes effect immediately at any point, including mid-record.
- Character handling:
  - Only cycles with EN=1 advance the parser.
  - Two hex characters form one byte, high nibble first.
- States and transitions:
  - IDLE: ':' goes to LEN and clears the running sum. CR, LF and space are ignored. Any other character goes to ERR (code 1).
  - LEN: 1 byte, into count. Then ADDR.
  - ADDR: 2 bytes, big-endian 16-bit offset. Then TYPE.
  - TYPE: 1 byte. If count=0, go to CSUM; otherwise go to DATA.
  - DATA: count bytes. Then CSUM.
  - CSUM: 1 byte. Then either IDLE, DONE or ERR (see Checksum and Record types).
  - DONE: terminal; all input is ignored until reset.
  - ERR: terminal; all input is ignored until reset.
- Inside a record, any non-hex character, including ':', CR or LF, goes to ERR with code 1.
- Checksum:
  - The running 8-bit sum covers every byte from LEN through CSUM, modulo 256.
  - At CSUM the sum must be 0x00; otherwise go to ERR with code 2.
  - On a match, pulse REC_OK in the cycle after the CSUM second-nibble EN.
- Record types:
  - 00 data:
    - Each completed data byte produces WE=1 in the cycle after the EN that carried its second nibble.
    - AB = (base + ((offset + i) mod 2^16)) mod 2^AW, where i is the byte index in the record.
    - The 16-bit offset wraps within the record and does not carry into base.
    - Writes are streamed before the checksum is verified; ERR code 2 flags any bad record after the fact.
  - 01 EOF: count must be 0, else code 3. On a valid checksum, DONE=1 and go to DONE.
  - 02 extended segment: count must be 2, else code 3. On a valid checksum, base = data16 << 4.
  - 04 extended linear: count must be 2, else code 3. On a valid checksum, base = data16 << 16, truncated to AW.
  - Other types: data bytes are consumed and checksummed but produce no WE, and base is unchanged.
- Code 3 is raised at the TYPE byte, before any data bytes are consumed.
- Error priority on a single character: code 1 over code 3.
- Base updates commit only after a good checksum; a bad 04 record leaves base unchanged.
- WE and REC_OK are never asserted in the same cycle. DB and AB hold their last values when WE=0.

Decomposition:
- Package hex_loader_pkg: state enum (IDLE, LEN, ADDR, TYPE, DATA, CSUM, DONE, ERR); record-type constants REC_DATA=8'h00, REC_EOF=8'h01, REC_ESA=8'h02, REC_ELA=8'h04; ERR_CODE constants.
- Sub-module hex_nibble: combinational ASCII to {valid, nibble[3:0]}, honouring ALLOW_LC.
- Top level: FSM, nibble/byte assembler, byte counter, checksum accumulator, base/offset registers.

Test Plan:
- Data record ":0200FF003C00C3" -> WE pulses with AB=0x000000FF DB=0x3C, then AB=0x00000100 DB=0x00. REC_OK pulses once. ERR=0.
- ELA then data ":020000040801F1" followed by ":01000000AA55" -> no WE during the first record; then WE with AB=0x08010000 DB=0xAA. REC_OK pulses twice.
- Offset wrap ":02FFFF001122CD" with base=0 -> WE at AB=0x0000FFFF DB=0x11, then AB=0x00000000 DB=0x22.
- EOF ":00000001FF" -> DONE=1 and stays 1. A subsequent ":0200FF003C00C3" produces no WE.
- Bad checksum ":0200FF003C00C4" -> two WE pulses, then ERR=1, ERR_CODE=2, no REC_OK.
- Bad character ":02G0" -> ERR_CODE=1 on the 'G' strobe. Separately, CLR=0 mid-record clears all outputs; ":00000001FF" after release sets DONE.

Source files
------------

// File: rtl/hex_loader_pkg.sv
// Shared types and constants for the Intel HEX streaming loader.
package hex_loader_pkg;

    typedef enum logic [2:0] {
        st_idle,
        st_len,
        st_addr,
        st_type,
        st_data,
        st_csum,
        st_done,
        st_err
    } state_t;

    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;
    localparam logic [7:0] REC_ESA  = 8'h02;
    localparam logic [7:0] REC_ELA  = 8'h04;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BADCHAR = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_LEN     = 2'd3;

    // Record types with a fixed payload size reject any other length.
    function automatic logic len_ok(input logic [7:0] rtype, input logic [7:0] cnt);
        if (rtype == REC_EOF)
            return cnt == 8'd0;
        if (rtype == REC_ESA || rtype == REC_ELA)
            return cnt == 8'd2;
        return 1'b1;
    endfunction

endpackage

// File: rtl/hex_nibble.sv
// ASCII hex digit decoder: returns a valid flag and the 4-bit value.
module hex_nibble #(
    parameter bit ALLOW_LC = 1'b1
) (
    input  logic [7:0] ch,
    output logic       vld,
    output logic [3:0] nib
);

    always_comb begin
        vld = 1'b0;
        nib = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            vld = 1'b1;
            nib = ch[3:0];
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            vld = 1'b1;
            nib = ch[3:0] + 4'd9;
        end else if (ALLOW_LC && ch >= 8'h61 && ch <= 8'h66) begin
            vld = 1'b1;
            nib = ch[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/hex_loader.sv
// Streaming Intel HEX parser: one ASCII character per EN strobe in,
// byte-wide memory writes out, with checksum and extended-address handling.
module hex_loader
    import hex_loader_pkg::*;
#(
    parameter int AW       = 32,
    parameter bit ALLOW_LC = 1'b1
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          EN,
    input  logic [7:0]    DI,
    output logic [AW-1:0] AB,
    output logic [7:0]    DB,
    output logic          WE,
    output logic          REC_OK,
    output logic          DONE,
    output logic          ERR,
    output logic [1:0]    ERR_CODE
);

    logic          nib_vld;
    logic [3:0]    nib;
    state_t        state;
    logic          lo_phase;
    logic [3:0]    hi_nib;
    logic [7:0]    cnt;
    logic [7:0]    idx;
    logic [7:0]    sum;
    logic [7:0]    rtype;
    logic [15:0]   offset;
    logic [15:0]   data16;
    logic [AW-1:0] base;
    logic [7:0]    cur_byte;
    logic [7:0]    sum_next;
    logic [15:0]   wr_off;

    hex_nibble #(.ALLOW_LC(ALLOW_LC)) u_nib (
        .ch  (DI),
        .vld (nib_vld),
        .nib (nib)
    );

    assign cur_byte = {hi_nib, nib};
    assign sum_next = sum + cur_byte;
    // The 16-bit offset wraps on its own; it never carries into the base.
    assign wr_off   = offset + {8'h00, idx};

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= st_idle;
            lo_phase <= 1'b0;
            hi_nib   <= 4'h0;
            cnt      <= 8'h00;
            idx      <= 8'h00;
            sum      <= 8'h00;
            rtype    <= 8'h00;
            offset   <= 16'h0000;
            data16   <= 16'h0000;
            base     <= '0;
            AB       <= '0;
            DB       <= 8'h00;
            WE       <= 1'b0;
            REC_OK   <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= ERR_NONE;
        end else begin
            WE     <= 1'b0;
            REC_OK <= 1'b0;
            if (EN) begin
                case (state)
                    st_idle: begin
                        if (DI == 8'h3A) begin
                            state    <= st_len;
                            sum      <= 8'h00;
                            lo_phase <= 1'b0;
                        end else if (DI != 8'h0D && DI != 8'h0A && DI != 8'h20) begin
                            state    <= st_err;
                            ERR      <= 1'b1;
                            ERR_CODE <= ERR_BADCHAR;
                        end
                    end
                    st_done, st_err: ;
                    default: begin
                        if (!nib_vld) begin
                            state    <= st_err;
                            ERR      <= 1'b1;
                            ERR_CODE <= ERR_BADCHAR;
                        end else if (!lo_phase) begin
                            hi_nib   <= nib;
                            lo_phase <= 1'b1;
                        end else begin
                            lo_phase <= 1'b0;
                            sum      <= sum_next;
                            case (state)
                                st_len: begin
                                    cnt   <= cur_byte;
                                    idx   <= 8'h00;
                                    state <= st_addr;
                                end
                                st_addr: begin
                                    if (idx == 8'h00) begin
                                        offset[15:8] <= cur_byte;
                                        idx          <= 8'h01;
                                    end else begin
                                        offset[7:0]  <= cur_byte;
                                        state        <= st_type;
                                    end
                                end
                                st_type: begin
                                    rtype <= cur_byte;
                                    idx   <= 8'h00;
                                    if (!len_ok(cur_byte, cnt)) begin
                                        state    <= st_err;
                                        ERR      <= 1'b1;
                                        ERR_CODE <= ERR_LEN;
                                    end else if (cnt == 8'h00) begin
                                        state <= st_csum;
                                    end else begin
                                        state <= st_data;
                                    end
                                end
                                st_data: begin
                                    if (rtype == REC_DATA) begin
                                        WE <= 1'b1;
                                        AB <= base + AW'(wr_off);
                                        DB <= cur_byte;
                                    end
                                    data16 <= {data16[7:0], cur_byte};
                                    idx    <= idx + 8'd1;
                                    if (idx + 8'd1 == cnt)
                                        state <= st_csum;
                                end
                                st_csum: begin
                                    if (sum_next != 8'h00) begin
                                        state    <= st_err;
                                        ERR      <= 1'b1;
                                        ERR_CODE <= ERR_CSUM;
                                    end else begin
                                        REC_OK <= 1'b1;
                                        state  <= st_idle;
                                        if (rtype == REC_EOF) begin
                                            DONE  <= 1'b1;
                                            state <= st_done;
                                        end else if (rtype == REC_ESA) begin
                                            base <= AW'({12'h000, data16, 4'h0});
                                        end else if (rtype == REC_ELA) begin
                                            base <= AW'({data16, 16'h0000});
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
